// File: rtl/program_loader.sv
// Byte-stream program loader: assembles big-endian words, writes them to consecutive
// memory addresses, reads each one back to verify, and holds the CPU off the memory port meanwhile.
module program_loader #(
    parameter int WORD    = 16,
    parameter int ADDRESS = 12,
    parameter int SIZE    = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDRESS-1:0] base_addr,
    input  logic [ADDRESS:0]   word_count,
    input  logic [7:0]         byte_data,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic [ADDRESS-1:0] mem_address,
    output logic [WORD-1:0]    mem_write_data,
    output logic               mem_write_enable,
    input  logic [WORD-1:0]    mem_read_data,
    output logic               busy,
    output logic               cpu_hold,
    output logic               done,
    output logic [ADDRESS:0]   words_written,
    output logic               verify_err
);

    typedef enum logic [2:0] {IDLE, HI, LO, WRITE, VERIFY, DONE} state_t;

    localparam logic [ADDRESS:0] ONE = 1;

    state_t             state, state_nxt;
    logic [ADDRESS-1:0] cur_addr;
    logic [ADDRESS:0]   count_r;
    logic [WORD-1:0]    word_r;
    logic               last_word;
    logic               load_go;

    assign load_go   = start && !abort;
    assign last_word = (words_written + ONE) == count_r;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        byte_ready       = 1'b0;
        mem_write_enable = 1'b0;
        done             = 1'b0;
        case (state)
            IDLE:    if (load_go) state_nxt = (word_count == '0) ? DONE : HI;
            HI: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = LO;
            end
            LO: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = WRITE;
            end
            WRITE: begin
                mem_write_enable = 1'b1;
                state_nxt        = VERIFY;
            end
            VERIFY:  state_nxt = last_word ? DONE : HI;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Abort outranks everything, including the write strobe and the done pulse.
        if (abort && state != IDLE) begin
            state_nxt        = IDLE;
            mem_write_enable = 1'b0;
            done             = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr      <= '0;
            count_r       <= '0;
            word_r        <= '0;
            words_written <= '0;
            verify_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (load_go) begin
                    cur_addr      <= base_addr;
                    count_r       <= word_count;
                    words_written <= '0;
                    verify_err    <= 1'b0;
                end
                HI:  if (byte_valid) word_r[WORD-1 -: 8] <= byte_data;
                LO:  if (byte_valid) word_r[7:0] <= byte_data;
                // Memory was written on the previous edge, so the readback is already current.
                VERIFY: if (!abort) begin
                    if (mem_read_data != word_r) verify_err <= 1'b1;
                    cur_addr      <= ADDRESS'((int'(cur_addr) + 1) % SIZE);
                    words_written <= words_written + ONE;
                end
                default: ;
            endcase
        end
    end

    assign mem_address    = cur_addr;
    assign mem_write_data = word_r;
    assign busy           = (state != IDLE);
    assign cpu_hold       = busy;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: random byte streams against a queue-based expectation of memory contents.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [11:0] base_addr;
    logic [12:0] word_count;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [11:0] mem_address;
    logic [15:0] mem_write_data;
    logic        mem_write_enable;
    logic [15:0] mem_read_data;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic [12:0] words_written;
    logic        verify_err;

    program_loader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data),
        .busy(busy), .cpu_hold(cpu_hold), .done(done),
        .words_written(words_written), .verify_err(verify_err)
    );

    always #5 clk = ~clk;

    // Memory model with optional single-address readback corruption.
    logic [15:0] mem [0:4095];
    logic        corrupt_en = 1'b0;
    logic [11:0] corrupt_addr = '0;

    always_comb begin
        mem_read_data = mem[mem_address];
        if (corrupt_en && mem_address == corrupt_addr) mem_read_data = mem[mem_address] ^ 16'h0001;
    end

    int we_cnt = 0, done_cnt = 0, ready_cnt = 0, hold_bad = 0;

    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem[mem_address] <= mem_write_data;
            we_cnt <= we_cnt + 1;
        end
        if (done)       done_cnt  <= done_cnt + 1;
        if (byte_ready) ready_cnt <= ready_cnt + 1;
    end

    always @(negedge clk) if (cpu_hold !== busy) hold_bad <= hold_bad + 1;

    int n_assert = 0, n_fail = 0;
    logic [7:0] byte_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a load, streams byte_q (optionally with random gaps), optionally aborts once
    // abort_after bytes have been accepted, and returns the cycles from start to done.
    task automatic run_load(input logic [11:0] base, input logic [12:0] cnt, input bit gaps,
                            input int abort_after, output int cycles);
        int idx = 0;
        int cyc = 0;
        int done0;
        bit fin = 0;
        done0 = done_cnt;
        @(negedge clk);
        base_addr = base; word_count = cnt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 2000) begin
            if (abort_after >= 0 && idx == abort_after) begin
                byte_valid = 1'b0;
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                fin = 1;
            end else begin
                byte_valid = (idx < byte_q.size()) && (!gaps || $urandom_range(0, 2) != 0);
                byte_data  = (idx < byte_q.size()) ? byte_q[idx] : 8'h00;
                if (byte_valid && byte_ready) idx++;
                @(negedge clk);
                cyc++;
                if (done_cnt != done0) fin = 1;
            end
        end
        byte_valid = 1'b0;
        cycles = cyc;
        chk("load_finished", 32'(fin), 32'd1);
    endtask

    task automatic check_mem(input logic [11:0] base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            logic [11:0] a;
            a = 12'((int'(base) + i) % 4096);
            chk("mem_word", 32'(mem[a]), 32'({byte_q[2*i], byte_q[2*i+1]}));
        end
    endtask

    initial begin
        int cyc, d0, w0, r0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; word_count = '0;
        byte_data = 8'h5A; byte_valid = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;

        // Reset with a byte offered
        repeat (2) @(negedge clk);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(mem_write_enable), 32'd0);
        chk("rst_words", 32'(words_written), 32'd0);
        chk("rst_verr", 32'(verify_err), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_wdata", 32'(mem_write_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_byte_ready", 32'(byte_ready), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        byte_valid = 1'b0;

        // Two words back-to-back
        byte_q = '{8'h20, 8'h14, 8'h10, 8'h15};
        d0 = done_cnt; w0 = we_cnt;
        run_load(12'h010, 13'd2, 1'b0, -1, cyc);
        chk("t2_cycles", 32'(cyc), 32'(4 * 2 + 1));
        chk("t2_done", 32'(done_cnt - d0), 32'd1);
        chk("t2_we", 32'(we_cnt - w0), 32'd2);
        chk("t2_words", 32'(words_written), 32'd2);
        chk("t2_verr", 32'(verify_err), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);
        check_mem(12'h010, 2);

        // Address wrap at the top of memory
        byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        d0 = done_cnt;
        run_load(12'hFFF, 13'd2, 1'b0, -1, cyc);
        chk("t3_done", 32'(done_cnt - d0), 32'd1);
        check_mem(12'hFFF, 2);
        chk("t3_mem0", 32'(mem[0]), 32'h0000CCDD);

        // Zero-length load
        byte_q = {};
        d0 = done_cnt; w0 = we_cnt; r0 = ready_cnt;
        run_load(12'h123, 13'd0, 1'b0, -1, cyc);
        chk("t4_cycles", 32'(cyc), 32'd1);
        chk("t4_done", 32'(done_cnt - d0), 32'd1);
        chk("t4_we", 32'(we_cnt - w0), 32'd0);
        chk("t4_ready", 32'(ready_cnt - r0), 32'd0);
        chk("t4_words", 32'(words_written), 32'd0);

        // Random gaps, three words
        byte_q = {};
        for (int i = 0; i < 6; i++) byte_q.push_back(8'($urandom));
        d0 = done_cnt; w0 = we_cnt;
        run_load(12'h200, 13'd3, 1'b1, -1, cyc);
        chk("t5_done", 32'(done_cnt - d0), 32'd1);
        chk("t5_we", 32'(we_cnt - w0), 32'd3);
        chk("t5_words", 32'(words_written), 32'd3);
        check_mem(12'h200, 3);

        // Abort after first byte
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        d0 = done_cnt; w0 = we_cnt;
        run_load(12'h300, 13'd2, 1'b1, 1, cyc);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_we", 32'(we_cnt - w0), 32'd0);
        chk("abort_words", 32'(words_written), 32'd0);
        chk("abort_mem", 32'(mem[12'h300]), 32'd0);

        // Corrupted readback of word 1
        byte_q = {};
        for (int i = 0; i < 6; i++) byte_q.push_back(8'($urandom));
        corrupt_en = 1'b1; corrupt_addr = 12'h401;
        d0 = done_cnt;
        run_load(12'h400, 13'd3, 1'b1, -1, cyc);
        corrupt_en = 1'b0;
        chk("t6_verr", 32'(verify_err), 32'd1);
        chk("t6_done", 32'(done_cnt - d0), 32'd1);
        chk("t6_words", 32'(words_written), 32'd3);
        check_mem(12'h400, 3);

        // Next start clears the sticky error
        byte_q = '{8'h5E, 8'hA7};
        run_load(12'h500, 13'd1, 1'b0, -1, cyc);
        chk("t6_verr_cleared", 32'(verify_err), 32'd0);
        check_mem(12'h500, 1);

        chk("hold_eq_busy", 32'(hold_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
